// File: rtl/prng_hpc2_feed_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prng_hpc2_feed_if
// Purpose  : Seed and random-word handshake bundle for prng_hpc2_feed.
//            The master side is whoever supplies seeds and consumes words.
//            The slave side is the randomness source itself.
// Revision : 1.0 - initial release
// ============================================================================
interface prng_hpc2_feed_if #(
  parameter int RNDW = 1
) ();
  logic [31:0]     seed;
  logic            seed_valid;
  logic            seed_ready;
  logic            reseed;
  logic [RNDW-1:0] rnd;
  logic            rnd_valid;
  logic            rnd_ready;

  modport master (
    output seed, seed_valid, reseed, rnd_ready,
    input  seed_ready, rnd, rnd_valid
  );

  modport slave (
    input  seed, seed_valid, reseed, rnd_ready,
    output seed_ready, rnd, rnd_valid
  );
endinterface
`default_nettype wire

// File: rtl/prng_hpc2_feed.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prng_hpc2_feed
// Purpose  : Fresh-randomness source for the rnd input of HPC2 masked-AND
//            gadgets. It holds a bank of RNDW 31-bit LFSRs. The bank is
//            seeded one word per handshake and warmed up for WARMUP steps.
//            It then streams one RNDW-bit word per accepted handshake.
//            rnd[k] is the MSB of LFSR k and is not registered, because the
//            gadget registers it.
// Revision : 1.0 - initial release
// ============================================================================
module prng_hpc2_feed #(
  parameter int D      = 2,
  parameter int RNDW   = D * (D - 1) / 2,
  parameter int WARMUP = 64
) (
  input  logic            clk,
  input  logic            rst,
  prng_hpc2_feed_if.slave bus
);

  // Both counters are at least one bit wide.
  // This keeps the declarations legal when WARMUP is 0.
  localparam int IDXW = (RNDW < 1)   ? 1 : $clog2(RNDW + 1);
  localparam int WCW  = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(RNDW - 1);
  localparam logic [WCW-1:0]  WCNT_LAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [30:0]     LFSR_ONE  = 31'h1;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] idx_next;
  logic [WCW-1:0]  wcnt;
  logic [WCW-1:0]  wcnt_next;
  logic            load;
  logic            step;
  logic [30:0]     seed_word;
  logic [RNDW-1:0] rnd_bits;
  logic [30:0]     lfsr [RNDW];

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  // Bit 31 of the seed word is never used.
  assign seed_word = (bus.seed[30:0] == 31'd0) ? LFSR_ONE : bus.seed[30:0];

  // Control state and counters. Reset aborts any partial seeding or warmup.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SEED;
      idx   <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      wcnt  <= wcnt_next;
    end
  end

  // Next state, the seed-load strobe and the bank-wide step strobe.
  // In RUN, reseed takes priority over a consumer handshake in the same cycle.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    wcnt_next  = wcnt;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      ST_SEED: begin
        if (bus.seed_valid) begin
          load = 1'b1;
          if (idx == IDX_LAST) begin
            idx_next   = '0;
            state_next = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      ST_WARMUP: begin
        step = 1'b1;
        if (wcnt == WCNT_LAST) begin
          wcnt_next  = '0;
          state_next = ST_RUN;
        end else begin
          wcnt_next = wcnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.reseed) begin
          state_next = ST_SEED;
          idx_next   = '0;
        end else if (bus.rnd_ready) begin
          step = 1'b1;
        end
      end
      default: begin
        state_next = ST_SEED;
        idx_next   = '0;
        wcnt_next  = '0;
      end
    endcase
  end

  for (genvar k = 0; k < RNDW; k++) begin : g_lfsr
    // Lane k: load when it is the addressed seed slot, otherwise shift on step.
    always_ff @(posedge clk) begin
      if (rst) begin
        lfsr[k] <= LFSR_ONE;
      end else if (load && (idx == IDXW'(k))) begin
        lfsr[k] <= seed_word;
      end else if (step) begin
        lfsr[k] <= {lfsr[k][29:0], lfsr[k][30] ^ lfsr[k][27]};
      end
    end

    assign rnd_bits[k] = lfsr[k][30];
  end

  assign bus.rnd        = rnd_bits;
  assign bus.seed_ready = (state == ST_SEED);
  assign bus.rnd_valid  = (state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_prng_hpc2_feed.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_prng_hpc2_feed
// Purpose  : Self-checking bench for prng_hpc2_feed.
//            One instance is built with d=2 and WARMUP=0.
//            A second instance is built with d=3 and WARMUP=64.
//            Both are compared against a behavioural LFSR-bank model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prng_hpc2_feed;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2;
  logic rst3;

  prng_hpc2_feed_if #(.RNDW(1)) b2 ();
  prng_hpc2_feed_if #(.RNDW(3)) b3 ();

  prng_hpc2_feed #(.D(2), .WARMUP(0)) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (b2)
  );

  prng_hpc2_feed #(.D(3), .WARMUP(64)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (b3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m2;
  int unsigned m3 [3];

  function automatic int unsigned lfsr_next(input int unsigned s);
    int unsigned fb;
    fb = ((s >> 30) ^ (s >> 27)) & 32'd1;
    return ((s << 1) | fb) & 32'h7fff_ffff;
  endfunction

  function automatic int unsigned seed_fix(input int unsigned w);
    int unsigned v;
    v = w & 32'h7fff_ffff;
    return (v == 0) ? 32'd1 : v;
  endfunction

  function automatic logic [2:0] exp3();
    return {m3[2][30], m3[1][30], m3[0][30]};
  endfunction

  task automatic step3();
    for (int k = 0; k < 3; k++) m3[k] = lfsr_next(m3[k]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- d=2 helpers ----------------
  task automatic seed2(input int unsigned w);
    b2.seed       = w;
    b2.seed_valid = 1'b1;
    check("d2_seed_ready", b2.seed_ready, 1);
    tick();
    b2.seed_valid = 1'b0;
    m2 = seed_fix(w);
    check("d2_valid_next_cycle", b2.rnd_valid, 1);
  endtask

  // The first 31 words of a seed-1 stream: 30 zeros, then a one.
  task automatic seed1_stream2();
    for (int i = 0; i < 31; i++) begin
      b2.rnd_ready = 1'b1;
      check("d2_seed1_word", b2.rnd, (i == 30) ? 1 : 0);
      tick();
      m2 = lfsr_next(m2);
    end
  endtask

  task automatic stream2(input int n);
    for (int i = 0; i < n; i++) begin
      b2.rnd_ready = 1'($urandom_range(0, 1));
      check("d2_rnd_valid", b2.rnd_valid, 1);
      check("d2_rnd", b2.rnd, m2[30]);
      tick();
      if (b2.rnd_ready) m2 = lfsr_next(m2);
    end
    b2.rnd_ready = 1'b0;
  endtask

  task automatic reseed2();
    logic [0:0] held;
    held         = b2.rnd;
    b2.reseed    = 1'b1;
    b2.rnd_ready = 1'b1;
    tick();
    b2.reseed    = 1'b0;
    b2.rnd_ready = 1'b0;
    check("d2_reseed_valid", b2.rnd_valid, 0);
    check("d2_reseed_ready", b2.seed_ready, 1);
    check("d2_reseed_nostep", b2.rnd, held);
  endtask

  // ---------------- d=3 helpers ----------------
  // Reseed pulses and stray seeds are applied where they must be ignored.
  task automatic seed3(input int unsigned w0, input int unsigned w1,
                       input int unsigned w2, input bit gaps);
    int unsigned w [3];
    w = '{w0, w1, w2};
    for (int k = 0; k < 3; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          b3.seed_valid = 1'b0;
          b3.reseed     = 1'($urandom_range(0, 1));
          tick();
        end
      end
      b3.seed       = w[k];
      b3.seed_valid = 1'b1;
      b3.reseed     = 1'($urandom_range(0, 1));
      check("d3_seed_ready", b3.seed_ready, 1);
      check("d3_seed_no_valid", b3.rnd_valid, 0);
      tick();
      m3[k] = seed_fix(w[k]);
    end
    b3.seed_valid = 1'b0;
    b3.reseed     = 1'b0;
  endtask

  // Must be called right after the last seed accept.
  task automatic wait_run3();
    int n;
    n = 0;
    check("d3_warm_seed_ready", b3.seed_ready, 0);
    while (!b3.rnd_valid && n < 200) begin
      b3.seed       = $urandom;
      b3.seed_valid = 1'($urandom_range(0, 1));
      b3.reseed     = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    b3.seed_valid = 1'b0;
    b3.reseed     = 1'b0;
    check("d3_warmup_cycles", n, 64);
    for (int k = 0; k < 64; k++) step3();
  endtask

  task automatic stream3(input int n, input bit rand_ready);
    logic [2:0] prev;
    for (int i = 0; i < n; i++) begin
      b3.rnd_ready = rand_ready ? 1'($urandom_range(0, 1)) : ~i[0];
      check("d3_rnd_valid", b3.rnd_valid, 1);
      check("d3_rnd", b3.rnd, exp3());
      prev = b3.rnd;
      tick();
      if (b3.rnd_ready) step3();
      else check("d3_hold", b3.rnd, prev);
    end
    b3.rnd_ready = 1'b0;
  endtask

  task automatic reseed3();
    logic [2:0] held;
    held         = b3.rnd;
    b3.reseed    = 1'b1;
    b3.rnd_ready = 1'b1;
    tick();
    b3.reseed    = 1'b0;
    b3.rnd_ready = 1'b0;
    check("d3_reseed_valid", b3.rnd_valid, 0);
    check("d3_reseed_ready", b3.seed_ready, 1);
    check("d3_reseed_nostep", b3.rnd, held);
  endtask

  // ---------------- sequence ----------------
  initial begin
    b2.seed = '0; b2.seed_valid = 1'b0; b2.reseed = 1'b0; b2.rnd_ready = 1'b0;
    b3.seed = '0; b3.seed_valid = 1'b0; b3.reseed = 1'b0; b3.rnd_ready = 1'b0;
    rst2 = 1'b1;
    rst3 = 1'b1;

    // Reset held for two cycles, checked after the first edge.
    tick();
    check("d2_rst_seed_ready", b2.seed_ready, 1);
    check("d2_rst_rnd_valid", b2.rnd_valid, 0);
    check("d2_rst_rnd", b2.rnd, 0);
    check("d3_rst_seed_ready", b3.seed_ready, 1);
    check("d3_rst_rnd_valid", b3.rnd_valid, 0);
    check("d3_rst_rnd", b3.rnd, 0);
    tick();
    rst2 = 1'b0;
    rst3 = 1'b0;
    m2 = 1;
    m3 = '{1, 1, 1};

    // d=2, WARMUP=0, seed 1.
    seed2(32'h0000_0001);
    seed1_stream2();
    stream2(20);

    // A zero seed with bit 31 set must reproduce the seed-1 stream.
    reseed2();
    seed2(32'h8000_0000);
    seed1_stream2();

    // Random seeds with random consumer back-pressure.
    for (int r = 0; r < 3; r++) begin
      reseed2();
      seed2($urandom);
      stream2(30);
    end

    // d=3, WARMUP=64: back-to-back seeds 1,2,3, then ready toggling 1,0,1,0.
    seed3(1, 2, 3, 1'b0);
    wait_run3();
    stream3(40, 1'b0);

    // Reseed and handshake together: reseed wins, then reseed with 1,2,3.
    reseed3();
    seed3(1, 2, 3, 1'b1);
    wait_run3();
    stream3(40, 1'b0);

    // Reset in the middle of seeding discards the partial seeds.
    reseed3();
    b3.seed       = 32'h1234_5678;
    b3.seed_valid = 1'b1;
    tick();
    b3.seed       = 32'h0bad_cafe;
    tick();
    b3.seed_valid = 1'b0;
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    check("d3_midrst_seed_ready", b3.seed_ready, 1);
    check("d3_midrst_rnd_valid", b3.rnd_valid, 0);
    check("d3_midrst_rnd", b3.rnd, 0);
    m3 = '{1, 1, 1};
    seed3($urandom, $urandom, $urandom, 1'b0);
    wait_run3();
    stream3(40, 1'b1);

    // Random reseed rounds, sometimes with zero-valued seed words.
    for (int r = 0; r < 3; r++) begin
      reseed3();
      seed3((r == 0) ? 32'h8000_0000 : $urandom, $urandom,
            (r == 1) ? 32'h0 : $urandom, 1'b1);
      wait_run3();
      stream3(30, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed hang, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/prng_hpc2_feed.md
# prng_hpc2_feed

Fresh-randomness source that feeds the `rnd` bus of HPC2 masked-AND gadgets. It holds a bank of 31-bit LFSRs, one per random bit a gadget consumes per cycle. The bank is seeded serially through a valid/ready port, warmed up for a fixed number of cycles, and then streams one fresh `RNDW`-bit word per accepted handshake. The block sits directly upstream of the gadget's `rnd` input.

## Interface
- `d`, 2: number of shares of the downstream gadget.
- `RNDW`, d*(d-1)/2: random bits per cycle; equals the gadget's `hpc2rnd`.
- `WARMUP`, 64: LFSR steps taken after seeding before output becomes valid; 0 is legal.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `seed`  in  32  seed word; bits [30:0] are used, bit 31 is ignored.
- `seed_valid`  in  1  seed word present.
- `seed_ready`  out  1  block accepts a seed word.
- `reseed`  in  1  request a new seeding sequence; honoured only in RUN.
- `rnd`  out  RNDW  fresh random bits; `rnd[k]` is bit 30 of LFSR k.
- `rnd_valid`  out  1  `rnd` is usable.
- `rnd_ready`  in  1  consumer takes `rnd` this cycle.

## Operation
- LFSR k has 31-bit state `s`. One step computes `fb = s[30]^s[27]` and sets `s <= {s[29:0], fb}`.
- FSM has three states: SEED, WARMUP, RUN.
- State is held in registers; `seed_ready = (state==SEED)` and `rnd_valid = (state==RUN)` are decoded from it.
- SEED:
  - Index counter `idx` runs 0..RNDW-1.
  - On `seed_valid && seed_ready`, LFSR `idx` loads `seed[30:0]`; if that value is 0, it loads 31'h1 instead.
  - Then `idx` increments.
  - The accept with `idx==RNDW-1` moves the FSM to WARMUP, or straight to RUN if WARMUP==0. `idx` returns to 0.
  - No LFSR steps in SEED.
- WARMUP:
  - All LFSRs step every cycle while a counter counts WARMUP cycles.
  - After the WARMUP-th step, the FSM enters RUN.
  - `seed_valid` is ignored.
- RUN:
  - `rnd` is driven combinationally from the LFSR MSBs.
  - On `rnd_valid && rnd_ready`, all LFSRs step once.
  - With `rnd_ready` low, state and `rnd` hold.
- `reseed` in RUN:
  - Next state is SEED and `idx` becomes 0.
  - No step occurs, even if `rnd_ready` is high the same cycle; `reseed` has priority.
  - LFSR contents are kept until they are overwritten.
- `reseed` outside RUN is ignored.
- `rst` has priority over everything. It sets state SEED, `idx=0`, warmup counter 0 and every LFSR to 31'h1.
- Reset values after `rst`: `seed_ready=1`, `rnd_valid=0`, `rnd` all zeros.
- A `rst` in any state aborts that state; partially loaded seeds are discarded.
- Counter widths:
  - `idx` is clog2(RNDW+1) bits.
  - The warmup counter is clog2(WARMUP+1) bits.
  - Neither counter wraps past its terminal value.

## Timing
- Seed handshake: one word per cycle at most; back-to-back accepts are allowed.
- Last seed accepted at edge t:
  - WARMUP>0: state is WARMUP after t, and `rnd_valid` rises after edge t+WARMUP.
  - WARMUP==0: `rnd_valid` is high in the cycle after edge t.
- In RUN, a word presented in cycle c and consumed at edge c is replaced by the stepped word in cycle c+1. Throughput is one word per cycle.
- `reseed` sampled at edge t: `rnd_valid` is 0 and `seed_ready` is 1 in cycle t+1.
- Zero latency from `rnd_ready` to the consumer: the gadget registers `rnd` itself, so this block adds no output register.

## Test plan
- Reset, d=2: assert `rst` for 2 cycles, then release -> `seed_ready=1`, `rnd_valid=0` and `rnd=0` immediately after the first reset edge.
- d=2, WARMUP=0:
  - Stimulus: seed 0x00000001, then `rnd_ready=1` continuously.
  - Required: `rnd_valid` high the next cycle; the first 30 words are 0 and the 31st word is 1 (the LFSR holds 0x40000004 at that point).
- Zero-seed substitution, d=2, WARMUP=0: seed 0x80000000 gives the identical stream to seed 1 (bit 31 is ignored, zero is replaced by 1).
- Stall and warmup, d=3, WARMUP=64:
  - Stimulus: seeds 1, 2, 3 back-to-back, then `rnd_ready` toggling 1,0,1,0.
  - Required: `rnd_valid` rises exactly 64 cycles after the third accept; `rnd` is unchanged across every `rnd_ready=0` cycle; the stream matches a software model stepped only on accepts.
- Reseed priority, d=3:
  - Stimulus: `reseed=1` and `rnd_ready=1` in the same RUN cycle.
  - Required: next cycle `rnd_valid=0` and `seed_ready=1`; after reseeding with 1, 2, 3, the output equals the post-reset sequence.
- Mid-seed reset, d=3: accept 2 seed words, assert `rst`, then send 3 fresh words -> output matches a model that never saw the first 2 words.
